// File: rtl/sram_loader_pkg.sv
// sram_loader_pkg: shared state type and width helpers for the SRAM loader.
package sram_loader_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, CLEAR, DONE} loader_state_t;

    function automatic int bytes_of(input int data_width);
        return data_width / 8;
    endfunction

    function automatic int lane_width(input int data_width);
        return (data_width / 8 > 1) ? $clog2(data_width / 8) : 1;
    endfunction

endpackage

// File: rtl/sram_loader_packer.sv
// byte_packer: assembles bytes little-endian into a word; word_o/valid_o
// describe the word completed by the current strobe, zero in unfilled lanes.
module byte_packer
    import sram_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [7:0]            data_i,
    input  logic                  strobe_i,
    input  logic                  last_i,
    input  logic                  flush_i,
    output logic [DATA_WIDTH-1:0] word_o,
    output logic                  valid_o
);

    localparam int BYTES = bytes_of(DATA_WIDTH);
    localparam int LW    = lane_width(DATA_WIDTH);

    logic [LW-1:0]         lane_q;
    logic [DATA_WIDTH-1:0] acc_q;

    assign word_o  = acc_q | (DATA_WIDTH'(data_i) << {lane_q, 3'b000});
    assign valid_o = strobe_i && (last_i || lane_q == LW'(BYTES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lane_q <= '0;
            acc_q  <= '0;
        end else if (flush_i || valid_o) begin
            lane_q <= '0;
            acc_q  <= '0;
        end else if (strobe_i) begin
            lane_q <= lane_q + LW'(1);
            acc_q  <= word_o;
        end
    end

endmodule

// File: rtl/sram_loader.sv
// sram_loader: streams bytes (or a constant fill) into a single-port SRAM,
// writing packed words sequentially from address 0 with registered outputs.
module sram_loader
    import sram_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start_load,
    input  logic                  start_clear,
    input  logic [DATA_WIDTH-1:0] clear_value,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_cen,
    output logic                  ram_we,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [ADDR_WIDTH:0]   word_count
);

    localparam logic [ADDR_WIDTH:0]   DEPTH     = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    loader_state_t         state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d, ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0] ram_data_q, ram_data_d, pk_word;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  ovf_q, ovf_d, cen_q, cen_d, ready_q, ready_d;
    logic                  busy_q, busy_d, done_q, done_d;
    logic                  start, xfer, pk_valid;

    assign start = (state_q == IDLE) && (start_load || start_clear);
    assign xfer  = in_valid && ready_q;

    byte_packer #(.DATA_WIDTH(DATA_WIDTH)) u_packer (
        .clk     (clk),
        .reset_n (reset_n),
        .data_i  (in_data),
        .strobe_i(xfer),
        .last_i  (in_last),
        .flush_i (start),
        .word_o  (pk_word),
        .valid_o (pk_valid)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // DONE lingers while the final write is still on the bus so done follows it
    always_comb begin
        state_d = (state_q == IDLE)  ? (start_clear ? CLEAR : start_load ? LOAD : IDLE) :
                  (state_q == LOAD)  ? ((xfer && in_last) ? DONE : LOAD) :
                  (state_q == CLEAR) ? ((ram_addr_q == LAST_ADDR) ? DONE : CLEAR) :
                  (cen_q ? DONE : IDLE);
    end

    always_comb begin
        addr_d     = addr_q;
        ovf_d      = ovf_q;
        count_d    = (cen_q && count_q != DEPTH) ? count_q + (ADDR_WIDTH+1)'(1) : count_q;
        ram_addr_d = ram_addr_q;
        ram_data_d = ram_data_q;
        cen_d      = 1'b0;
        if (start) begin
            addr_d  = '0;
            ovf_d   = 1'b0;
            count_d = '0;
            if (start_clear) begin
                cen_d      = 1'b1;
                ram_addr_d = '0;
                ram_data_d = clear_value;
            end
        end else if (state_q == LOAD && pk_valid && !ovf_q) begin
            cen_d      = 1'b1;
            ram_addr_d = addr_q;
            ram_data_d = pk_word;
            addr_d     = addr_q + ADDR_WIDTH'(1);
            ovf_d      = (addr_q == LAST_ADDR);
        end else if (state_q == CLEAR && ram_addr_q != LAST_ADDR) begin
            cen_d      = 1'b1;
            ram_addr_d = ram_addr_q + ADDR_WIDTH'(1);
        end
        ready_d = (state_d == LOAD);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE) && !cen_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q     <= '0;
            ovf_q      <= 1'b0;
            count_q    <= '0;
            ram_addr_q <= '0;
            ram_data_q <= '0;
            cen_q      <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            ovf_q      <= ovf_d;
            count_q    <= count_d;
            ram_addr_q <= ram_addr_d;
            ram_data_q <= ram_data_d;
            cen_q      <= cen_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign in_ready   = ready_q;
    assign ram_addr   = ram_addr_q;
    assign ram_data   = ram_data_q;
    assign ram_cen    = cen_q;
    assign ram_we     = cen_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign overflow   = ovf_q;
    assign word_count = count_q;

endmodule

// File: tb/tb_sram_loader.sv
// tb_sram_loader: directed checks of three loader configurations against RAM models.
module tb_sram_loader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0, in_last = 1'b0;
    logic [31:0] clear_value = '0;
    logic        sl_a = 0, sc_a = 0, sl_b = 0, sc_b = 0, sl_c = 0, sc_c = 0;

    logic        rdy_a, cen_a, we_a, busy_a, done_a, ovf_a;
    logic [3:0]  addr_a;
    logic [15:0] data_a;
    logic [4:0]  wc_a;
    logic        rdy_b, cen_b, we_b, busy_b, done_b, ovf_b;
    logic [3:0]  addr_b;
    logic [31:0] data_b;
    logic [4:0]  wc_b;
    logic        rdy_c, cen_c, we_c, busy_c, done_c, ovf_c;
    logic [3:0]  addr_c;
    logic [7:0]  data_c;
    logic [4:0]  wc_c;

    logic [15:0] mem_a [16];
    logic [31:0] mem_b [16];
    logic [7:0]  mem_c [16];
    int wr_a = 0, wr_b = 0, wr_c = 0, dn_a = 0;
    int n_checks = 0, n_fail = 0;

    always #5 clk = ~clk;

    sram_loader #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) u_a (
        .clk(clk), .reset_n(reset_n), .start_load(sl_a), .start_clear(sc_a),
        .clear_value(clear_value[15:0]), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(rdy_a), .ram_addr(addr_a), .ram_data(data_a),
        .ram_cen(cen_a), .ram_we(we_a), .busy(busy_a), .done(done_a),
        .overflow(ovf_a), .word_count(wc_a));

    sram_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) u_b (
        .clk(clk), .reset_n(reset_n), .start_load(sl_b), .start_clear(sc_b),
        .clear_value(clear_value), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(rdy_b), .ram_addr(addr_b), .ram_data(data_b),
        .ram_cen(cen_b), .ram_we(we_b), .busy(busy_b), .done(done_b),
        .overflow(ovf_b), .word_count(wc_b));

    sram_loader #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) u_c (
        .clk(clk), .reset_n(reset_n), .start_load(sl_c), .start_clear(sc_c),
        .clear_value(clear_value[7:0]), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(rdy_c), .ram_addr(addr_c), .ram_data(data_c),
        .ram_cen(cen_c), .ram_we(we_c), .busy(busy_c), .done(done_c),
        .overflow(ovf_c), .word_count(wc_c));

    always @(posedge clk) begin
        if (cen_a && we_a) begin mem_a[addr_a] <= data_a; wr_a <= wr_a + 1; end
        if (cen_b && we_b) begin mem_b[addr_b] <= data_b; wr_b <= wr_b + 1; end
        if (cen_c && we_c) begin mem_c[addr_c] <= data_c; wr_c <= wr_c + 1; end
        if (done_a) dn_a <= dn_a + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        in_data  = d;
        in_valid = 1'b1;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({rdy_a, cen_a, we_a, busy_a, done_a, ovf_a, addr_a, data_a, wc_a} !== '0) begin
            n_fail++;
            $display("FAIL reset_a: got %b/%h/%h/%h exp all zero",
                     {rdy_a, cen_a, we_a, busy_a, done_a, ovf_a}, addr_a, data_a, wc_a);
        end
        n_checks++;
        if ({rdy_c, cen_c, busy_c, done_c, ovf_c, addr_c, data_c, wc_c} !== '0) begin
            n_fail++;
            $display("FAIL reset_c: got %b/%h/%h/%h exp all zero",
                     {rdy_c, cen_c, busy_c, done_c, ovf_c}, addr_c, data_c, wc_c);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_load16();
        int w0 = wr_a, d0 = dn_a;
        sl_a = 1'b1;
        tick();
        sl_a = 1'b0;
        n_checks++;
        if ({busy_a, rdy_a, cen_a} !== 3'b110) begin
            n_fail++;
            $display("FAIL load16_start: busy/ready/cen got %b exp 110", {busy_a, rdy_a, cen_a});
        end
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b1);
        n_checks++;
        if ({cen_a, we_a, addr_a, data_a, done_a, rdy_a} !== {2'b11, 4'd1, 16'h4433, 2'b00}) begin
            n_fail++;
            $display("FAIL load16_final_write: cen=%b addr=%h data=%h done=%b rdy=%b exp 1/1/4433/0/0",
                     cen_a, addr_a, data_a, done_a, rdy_a);
        end
        tick();
        n_checks++;
        if ({done_a, cen_a, busy_a} !== 3'b101) begin
            n_fail++;
            $display("FAIL load16_done: done/cen/busy got %b exp 101", {done_a, cen_a, busy_a});
        end
        tick();
        tick();
        n_checks++;
        if ({mem_a[0], mem_a[1]} !== {16'h2211, 16'h4433}) begin
            n_fail++;
            $display("FAIL load16_mem: got %h %h exp 2211 4433", mem_a[0], mem_a[1]);
        end
        n_checks++;
        if (wr_a - w0 != 2 || wc_a !== 5'd2 || ovf_a !== 1'b0 || dn_a - d0 != 1 || busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL load16_counts: writes=%0d wc=%0d ovf=%b dones=%0d busy=%b exp 2/2/0/1/0",
                     wr_a - w0, wc_a, ovf_a, dn_a - d0, busy_a);
        end
    endtask

    task automatic test_load32();
        int w0 = wr_b;
        mem_b[1] = 32'hFFFF_FFFF;
        sl_b = 1'b1;
        tick();
        sl_b = 1'b0;
        for (int i = 1; i <= 5; i++) send_byte(8'(i), i == 5);
        tick();
        tick();
        n_checks++;
        if ({mem_b[0], mem_b[1]} !== {32'h0403_0201, 32'h0000_0005}) begin
            n_fail++;
            $display("FAIL load32_mem: got %h %h exp 04030201 00000005", mem_b[0], mem_b[1]);
        end
        n_checks++;
        if (wr_b - w0 != 2 || wc_b !== 5'd2) begin
            n_fail++;
            $display("FAIL load32_counts: writes=%0d wc=%0d exp 2/2", wr_b - w0, wc_b);
        end
    endtask

    task automatic test_overflow();
        int w0 = wr_c;
        logic rdy_ok = 1'b1, mem_ok = 1'b1;
        sl_c = 1'b1;
        tick();
        sl_c = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (rdy_c !== 1'b1) rdy_ok = 1'b0;
            send_byte(8'(i + 1), i == 19);
        end
        n_checks++;
        if (rdy_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_ready: in_ready dropped during load got %b exp 1", rdy_ok);
        end
        n_checks++;
        if ({done_c, cen_c, ovf_c} !== 3'b101 || wc_c !== 5'd16) begin
            n_fail++;
            $display("FAIL ovf_done: done/cen/ovf got %b wc=%0d exp 101 wc=16",
                     {done_c, cen_c, ovf_c}, wc_c);
        end
        tick();
        for (int k = 0; k < 16; k++) if (mem_c[k] !== 8'(k + 1)) mem_ok = 1'b0;
        n_checks++;
        if (wr_c - w0 != 16 || mem_ok !== 1'b1 || busy_c !== 1'b0 || ovf_c !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_writes: writes=%0d mem_ok=%b busy=%b ovf=%b exp 16/1/0/1",
                     wr_c - w0, mem_ok, busy_c, ovf_c);
        end
    endtask

    task automatic test_clear();
        int w0 = wr_a;
        logic seq_ok = 1'b1, mem_ok = 1'b1;
        clear_value = 32'h0000_00A5;
        sc_a = 1'b1;
        tick();
        sc_a = 1'b0;
        n_checks++;
        if ({busy_a, rdy_a} !== 2'b10) begin
            n_fail++;
            $display("FAIL clear_start: busy/ready got %b exp 10", {busy_a, rdy_a});
        end
        for (int i = 0; i < 16; i++) begin
            if (cen_a !== 1'b1 || addr_a !== 4'(i) || data_a !== 16'h00A5 || done_a !== 1'b0)
                seq_ok = 1'b0;
            tick();
        end
        n_checks++;
        if (seq_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_seq: write sequence ok=%b exp 1", seq_ok);
        end
        n_checks++;
        if ({done_a, cen_a} !== 2'b10 || wc_a !== 5'd16) begin
            n_fail++;
            $display("FAIL clear_done: done/cen got %b wc=%0d exp 10 wc=16", {done_a, cen_a}, wc_a);
        end
        for (int k = 0; k < 16; k++) if (mem_a[k] !== 16'h00A5) mem_ok = 1'b0;
        n_checks++;
        if (mem_ok !== 1'b1 || wr_a - w0 != 16) begin
            n_fail++;
            $display("FAIL clear_mem: mem_ok=%b writes=%0d exp 1/16", mem_ok, wr_a - w0);
        end
        tick();
    endtask

    task automatic test_both_starts();
        int w0 = wr_a, budget = 0;
        logic mem_ok = 1'b1;
        clear_value = 32'h0000_003C;
        sl_a = 1'b1;
        sc_a = 1'b1;
        tick();
        sl_a = 1'b0;
        sc_a = 1'b0;
        n_checks++;
        if ({cen_a, rdy_a, data_a} !== {2'b10, 16'h003C}) begin
            n_fail++;
            $display("FAIL both_clear_wins: cen=%b rdy=%b data=%h exp 1/0/003c", cen_a, rdy_a, data_a);
        end
        tick();
        tick();
        sl_a = 1'b1;
        tick();
        sl_a = 1'b0;
        while (done_a !== 1'b1 && budget < 40) begin
            tick();
            budget++;
        end
        n_checks++;
        if (done_a !== 1'b1) begin
            n_fail++;
            $display("FAIL both_timeout: done got %b exp 1", done_a);
        end
        tick();
        tick();
        for (int k = 0; k < 16; k++) if (mem_a[k] !== 16'h003C) mem_ok = 1'b0;
        n_checks++;
        if ({busy_a, rdy_a} !== 2'b00 || mem_ok !== 1'b1 || wr_a - w0 != 16) begin
            n_fail++;
            $display("FAIL both_ignored_load: busy/rdy=%b mem_ok=%b writes=%0d exp 00/1/16",
                     {busy_a, rdy_a}, mem_ok, wr_a - w0);
        end
    endtask

    task automatic test_reset_mid();
        int w0 = wr_b;
        sl_b = 1'b1;
        tick();
        sl_b = 1'b0;
        send_byte(8'h91, 1'b0);
        send_byte(8'h92, 1'b0);
        send_byte(8'h93, 1'b0);
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({rdy_b, cen_b, we_b, busy_b, done_b, ovf_b, addr_b, data_b, wc_b} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: got %b/%h/%h/%h exp all zero",
                     {rdy_b, cen_b, we_b, busy_b, done_b, ovf_b}, addr_b, data_b, wc_b);
        end
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        n_checks++;
        if (wr_b != w0) begin
            n_fail++;
            $display("FAIL rst_mid_nowrite: writes=%0d exp 0", wr_b - w0);
        end
        sl_b = 1'b1;
        tick();
        sl_b = 1'b0;
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b0);
        send_byte(8'hDD, 1'b1);
        n_checks++;
        if ({cen_b, addr_b, data_b} !== {1'b1, 4'd0, 32'hDDCC_BBAA}) begin
            n_fail++;
            $display("FAIL rst_mid_reload: cen=%b addr=%h data=%h exp 1/0/ddccbbaa", cen_b, addr_b, data_b);
        end
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_load16();
        test_load32();
        test_overflow();
        test_clear();
        test_both_starts();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_loader.md
# sram_loader

Write-side engine for the synchronous single-port SRAM blocks (ROM shadows, tile/sprite RAMs) used throughout the core. It accepts a byte stream from the bridge data loader over a valid/ready handshake, packs bytes little-endian into `DATA_WIDTH` words, and writes them sequentially from address 0. It also provides a clear mode that fills the whole array with a constant. Its `ram_*` outputs connect directly to the RAM's address, data, enable and write-enable inputs.

## Interface
- `DATA_WIDTH`, 8: RAM word width; must be a multiple of 8. `BYTES = DATA_WIDTH/8`.
- `ADDR_WIDTH`, 10: RAM address width; depth `2**ADDR_WIDTH` words.
- `clk` in 1: single clock, shared with the RAM.
- `reset_n` in 1: asynchronous, active-low reset.
- `start_load` in 1: one-cycle pulse; begins a stream load.
- `start_clear` in 1: one-cycle pulse; begins a full-array fill.
- `clear_value` in DATA_WIDTH: fill word; sampled on `start_clear`.
- `in_data` in 8: stream byte.
- `in_valid` in 1: `in_data` is valid.
- `in_last` in 1: qualifies the final byte of the stream.
- `in_ready` out 1: loader accepts a byte this cycle.
- `ram_addr` out ADDR_WIDTH: RAM address.
- `ram_data` out DATA_WIDTH: RAM write data.
- `ram_cen` out 1: RAM enable.
- `ram_we` out 1: RAM write enable.
- `busy` out 1: high in LOAD, CLEAR and DONE.
- `done` out 1: one-cycle pulse when an operation completes.
- `overflow` out 1: sticky; the stream exceeded RAM depth. Cleared by the next start.
- `word_count` out ADDR_WIDTH+1: words written by the last or current operation.

## Operation
- States: IDLE, LOAD, CLEAR, DONE.
- IDLE:
  - `start_clear` -> CLEAR. Clear wins if both starts are asserted in the same cycle.
  - `start_load` -> LOAD.
  - Both starts reset the address, byte lane, `word_count` and `overflow`.
  - Starts are ignored in every other state.
- LOAD:
  - `in_ready`=1; a byte transfers when `in_valid && in_ready`.
  - Byte k of a word goes to bits `[8k+7:8k]`.
  - When lane `BYTES-1` transfers, or `in_last` transfers, the packed word is written at the current address. Unfilled upper lanes are zero. The address then increments.
  - After the write at address `2**ADDR_WIDTH-1`, the address wraps to 0 and `overflow` sets. While `overflow` is set, no further writes are issued. Bytes are still accepted and discarded until `in_last`.
  - `in_last` transfer -> DONE, after its final write has been issued.
- CLEAR:
  - Writes `clear_value` to addresses 0 .. `2**ADDR_WIDTH-1`, one per cycle.
  - After the last address -> DONE.
  - `in_ready`=0.
- DONE: `done`=1 for one cycle -> IDLE.
- `word_count` increments once per issued write and saturates at `2**ADDR_WIDTH`.
- Reset mid-operation: return to IDLE immediately; any partial word is dropped and no write is issued.

## Timing
- All outputs are registered.
- Reset values:
  - state IDLE.
  - `in_ready`, `ram_cen`, `ram_we`, `busy`, `done`, `overflow`: 0.
  - `ram_addr`, `ram_data`, `word_count`: 0.
- Start pulse at cycle N: `busy`=1 at N+1. For CLEAR, the first write is presented at N+1. For LOAD, `in_ready`=1 at N+1.
- Word-completing transfer at cycle T: `ram_addr`, `ram_data` and `ram_cen`=`ram_we`=1 are presented during T+1 for exactly one cycle.
- With `BYTES`=1, back-to-back writes occur every cycle.
- Writes are never stalled; `in_ready` stays high for the whole of LOAD.
- CLEAR takes `2**ADDR_WIDTH` write cycles. `done` pulses in the cycle after the last write.
- LOAD: `done` pulses in the cycle after the final write, or in the cycle after the `in_last` transfer if no write is issued (overflow).
- `ram_cen`=0 whenever no write is being issued. The loader never issues reads.

## Structure
- Package `sram_loader_pkg`:
  - state enum `loader_state_t` (IDLE, LOAD, CLEAR, DONE).
  - function computing `BYTES` and lane-index width (`$clog2(BYTES)`, minimum 1).
- Sub-module `byte_packer`: lane counter plus shift/assemble register.
  - Inputs: byte, strobe, last, flush.
  - Outputs: word, word-valid pulse.
- Top level holds the FSM, address counter, overflow and `word_count`.

## Test plan
- DATA_WIDTH=16, ADDR_WIDTH=4; load bytes 0x11,0x22,0x33,0x44 with `in_last` on 0x44 -> two writes, addr0=0x2211 and addr1=0x4433. `word_count`=2, `done` pulses once, `overflow`=0.
- DATA_WIDTH=32; load 5 bytes 0x01..0x05 with `in_last` on 0x05 -> addr0=0x04030201, addr1=0x00000005.
- ADDR_WIDTH=4, DATA_WIDTH=8; stream 20 bytes -> 16 writes (addr 0..15), then `overflow`=1. The 4 remaining bytes are accepted with no write, `word_count`=16, and `done` pulses after `in_last`.
- `start_clear` with `clear_value`=0xA5, ADDR_WIDTH=4 -> writes on 16 consecutive cycles, addr 0..15, then `done`. Read-back of the RAM model gives all 0xA5.
- `start_load` and `start_clear` in the same cycle -> CLEAR runs. A second `start_load` during CLEAR is ignored.
- Assert `reset_n`=0 after 3 bytes with DATA_WIDTH=32 -> all outputs return to reset values, no write is issued, and a following load starts at addr0.
